// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared constants, state type and pick helper for the AXI-lite read arbiter
package axi_rd_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int RESP_W_DEF = 2;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_AR   = 2'd1;
    localparam logic [1:0] ARB_R    = 2'd2;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_AR   = ARB_AR,
        ST_R    = ARB_R
    } arb_state_e;

    // Fixed priority: the load/store unit (master 1) wins whenever it asks.
    function automatic logic fixed_pick(input logic [1:0] req);
        return req[1] ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/rd_arb_pick.sv
// rtl/rd_arb_pick.sv - combinational winner selection; round-robin tie-break under ARB_ROUND_ROBIN_EN
module rd_arb_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

`ifdef ARB_ROUND_ROBIN_EN
    // A tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = fixed_pick(req);
        end
    end
`else
    // A tie always goes to master 1; the history input has no role here.
    always_comb begin
        any    = |req;
        winner = fixed_pick(req);
    end

    logic last_unused;
    assign last_unused = last;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master one-slave AXI-lite read arbiter (ARB_ROUND_ROBIN_EN selects round-robin ties)
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RESP_W = RESP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic              m0_arvalid_i,
    output logic              m0_arready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [RESP_W-1:0] m0_rresp_o,
    output logic              m0_rvalid_o,
    input  logic              m0_rready_i,

    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic              m1_arvalid_i,
    output logic              m1_arready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [RESP_W-1:0] m1_rresp_o,
    output logic              m1_rvalid_o,
    input  logic              m1_rready_i,

    output logic [ADDR_W-1:0] s_araddr_o,
    output logic              s_arvalid_o,
    input  logic              s_arready_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic [RESP_W-1:0] s_rresp_i,
    input  logic              s_rvalid_i,
    output logic              s_rready_o
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       gnt;
    logic       gnt_nxt;
    logic       pick_winner;
    logic       pick_any;
    logic       pick_last;
    logic       r_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // Remember who was served most recently so the next tie goes the other way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= GNT_M1;
        end else if (r_done) begin
            last_q <= gnt;
        end
    end

    assign pick_last = last_q;
`else
    assign pick_last = GNT_M1;
`endif

    rd_arb_pick u_pick (
        .req    ({m1_arvalid_i, m0_arvalid_i}),
        .last   (pick_last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // State and grant registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= GNT_M0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    // Next-state logic and channel routing; outputs depend on state, grant and inputs only.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        r_done       = 1'b0;

        s_araddr_o   = '0;
        s_arvalid_o  = 1'b0;
        s_rready_o   = 1'b0;
        m0_arready_o = 1'b0;
        m1_arready_o = 1'b0;
        m0_rvalid_o  = 1'b0;
        m1_rvalid_o  = 1'b0;
        m0_rdata_o   = '0;
        m1_rdata_o   = '0;
        m0_rresp_o   = '0;
        m1_rresp_o   = '0;

        case (state)
            ST_IDLE: begin
                // Grant is decided here but nothing is driven until AR.
                if (pick_any) begin
                    gnt_nxt   = pick_winner;
                    state_nxt = ST_AR;
                end
            end

            ST_AR: begin
                s_arvalid_o = 1'b1;
                if (gnt == GNT_M1) begin
                    s_araddr_o   = m1_araddr_i;
                    m1_arready_o = s_arready_i;
                end else begin
                    s_araddr_o   = m0_araddr_i;
                    m0_arready_o = s_arready_i;
                end
                if (s_arready_i) begin
                    state_nxt = ST_R;
                end
            end

            ST_R: begin
                if (gnt == GNT_M1) begin
                    s_rready_o  = m1_rready_i;
                    m1_rvalid_o = s_rvalid_i;
                    m1_rdata_o  = s_rdata_i;
                    m1_rresp_o  = s_rresp_i;
                end else begin
                    s_rready_o  = m0_rready_i;
                    m0_rvalid_o = s_rvalid_i;
                    m0_rdata_o  = s_rdata_i;
                    m0_rresp_o  = s_rresp_i;
                end
                r_done = s_rvalid_i & s_rready_o;
                if (r_done) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter with random slave timing and rule-based grant model
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_araddr_i, m1_araddr_i;
    logic        m0_arvalid_i, m1_arvalid_i;
    logic        m0_arready_o, m1_arready_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [1:0]  m0_rresp_o, m1_rresp_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic        m0_rready_i, m1_rready_i;
    logic [31:0] s_araddr_o;
    logic        s_arvalid_o;
    logic        s_arready_i;
    logic [31:0] s_rdata_i;
    logic [1:0]  s_rresp_i;
    logic        s_rvalid_i;
    logic        s_rready_o;

    int          checks = 0;
    int          errs = 0;
    logic [33:0] exp0[$];
    logic [33:0] exp1[$];
    int          mon_rd0 = 0;
    int          mon_rd1 = 0;
    logic        glog[$];
    int          rr_mode0 = 0;
    int          rr_mode1 = 0;
    int          ar_lat_min = 0, ar_lat_max = 0;
    int          r_lat_min = 0, r_lat_max = 0;

    axi_rd_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_araddr_i  (m0_araddr_i),
        .m0_arvalid_i (m0_arvalid_i),
        .m0_arready_o (m0_arready_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_rresp_o   (m0_rresp_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rready_i  (m0_rready_i),
        .m1_araddr_i  (m1_araddr_i),
        .m1_arvalid_i (m1_arvalid_i),
        .m1_arready_o (m1_arready_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_rresp_o   (m1_rresp_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rready_i  (m1_rready_i),
        .s_araddr_o   (s_araddr_o),
        .s_arvalid_o  (s_arvalid_o),
        .s_arready_i  (s_arready_i),
        .s_rdata_i    (s_rdata_i),
        .s_rresp_i    (s_rresp_i),
        .s_rvalid_i   (s_rvalid_i),
        .s_rready_o   (s_rready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5EADBEEF;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return a[5:4];
    endfunction

    function automatic logic rready_for(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(1, 0));
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic request(input int m, input logic [31:0] a);
        if (m == 0) begin
            m0_araddr_i  = a;
            m0_arvalid_i = 1'b1;
            exp0.push_back({mem_resp(a), mem_data(a)});
        end else begin
            m1_araddr_i  = a;
            m1_arvalid_i = 1'b1;
            exp1.push_back({mem_resp(a), mem_data(a)});
        end
    endtask

    // One master-side cycle: observe at negedge, update drives just after posedge.
    task automatic step();
        logic h0, h1;
        @(negedge clk);
        h0 = m0_arvalid_i & m0_arready_o;
        h1 = m1_arvalid_i & m1_arready_o;
        @(posedge clk);
        #2;
        if (h0) begin m0_arvalid_i = 1'b0; m0_araddr_i = '0; end
        if (h1) begin m1_arvalid_i = 1'b0; m1_araddr_i = '0; end
        m0_rready_i = rready_for(rr_mode0);
        m1_rready_i = rready_for(rr_mode1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((mon_rd0 != exp0.size() || mon_rd1 != exp1.size()) && n < 400) begin
            step();
            n++;
        end
        chk({nm, "_drain_done"}, 64'(n < 400), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid_ready"}, {s_arvalid_o, s_rready_o, m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o}, 0);
        chk({nm, "_araddr"}, s_araddr_o, 0);
        chk({nm, "_m0_r"}, {m0_rresp_o, m0_rdata_o}, 0);
        chk({nm, "_m1_r"}, {m1_rresp_o, m1_rdata_o}, 0);
    endtask

    // Slave model: programmable AR/R latency, data is a fixed function of the address.
    initial begin
        logic        e_hs_ar, e_hs_r, e_sarv, r_pend;
        logic [31:0] e_addr, r_addr;
        int          ar_cnt, ar_tgt, r_cnt;
        s_arready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0;
        r_pend = 1'b0; r_addr = '0; ar_cnt = 0; ar_tgt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            e_hs_ar = rst & s_arvalid_o & s_arready_i;
            e_hs_r  = rst & s_rvalid_i & s_rready_o;
            e_sarv  = rst & s_arvalid_o;
            e_addr  = s_araddr_o;
            @(posedge clk);
            #1;
            if (!rst) begin
                s_arready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0;
                r_pend = 1'b0; ar_cnt = 0;
            end else begin
                s_arready_i = 1'b0;
                if (e_hs_r) begin
                    s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0; r_pend = 1'b0;
                end
                if (e_hs_ar) begin
                    r_pend = 1'b1;
                    r_addr = e_addr;
                    r_cnt  = int'($urandom_range(r_lat_max, r_lat_min));
                    ar_cnt = 0;
                end else if (r_pend && !s_rvalid_i) begin
                    if (r_cnt <= 0) begin
                        s_rvalid_i = 1'b1;
                        s_rdata_i  = mem_data(r_addr);
                        s_rresp_i  = mem_resp(r_addr);
                    end else begin
                        r_cnt--;
                    end
                end
                if (e_sarv && !e_hs_ar) begin
                    if (ar_cnt == 0) ar_tgt = int'($urandom_range(ar_lat_max, ar_lat_min));
                    if (ar_cnt >= ar_tgt) s_arready_i = 1'b1;
                    ar_cnt++;
                end else if (!e_sarv) begin
                    ar_cnt = 0;
                end
            end
        end
    end

    // Monitor: grant model, routing checks and response scoreboard.
    initial begin
        logic [1:0] prev_req, prev_pend;
        logic       prev_sarv, cur_g, in_r, last_done, w, exp_w, ar_hs, r_hs;
        prev_req = '0; prev_pend = '0; prev_sarv = 1'b0; cur_g = 1'b0; in_r = 1'b0; last_done = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = '0; prev_pend = '0; prev_sarv = 1'b0; in_r = 1'b0; last_done = 1'b1;
                mon_rd0 = exp0.size();
                mon_rd1 = exp1.size();
            end else begin
                if (prev_pend[0]) chk("m0_arvalid_held", m0_arvalid_i, 1);
                if (prev_pend[1]) chk("m1_arvalid_held", m1_arvalid_i, 1);

                if (s_arvalid_o && !prev_sarv) begin
                    w = m1_arvalid_i && (s_araddr_o == m1_araddr_i);
                    chk("grant_addr", s_araddr_o, w ? m1_araddr_i : m0_araddr_i);
                    chk("grant_arvalid", w ? m1_arvalid_i : m0_arvalid_i, 1);
                    chk("grant_had_req", 64'(prev_req != 2'b00), 1);
`ifdef ARB_ROUND_ROBIN_EN
                    exp_w = (prev_req == 2'b11) ? ~last_done : prev_req[1];
`else
                    exp_w = (prev_req == 2'b11) ? 1'b1 : prev_req[1];
`endif
                    chk("grant_pick", w, exp_w);
                    glog.push_back(w);
                    cur_g = w;
                end

                chk("arready_route", {m1_arready_o, m0_arready_o},
                    s_arvalid_o ? (cur_g ? {s_arready_i, 1'b0} : {1'b0, s_arready_i}) : 2'b00);

                if (in_r) begin
                    chk("s_rready_route", s_rready_o, cur_g ? m1_rready_i : m0_rready_i);
                    chk("rvalid_route", {m1_rvalid_o, m0_rvalid_o}, cur_g ? {s_rvalid_i, 1'b0} : {1'b0, s_rvalid_i});
                end else begin
                    chk("r_quiet", {s_rready_o, m1_rvalid_o, m0_rvalid_o}, 0);
                end

                if (m0_rvalid_o && m0_rready_i) begin
                    if (mon_rd0 < exp0.size()) begin
                        chk("m0_rresp_rdata", {m0_rresp_o, m0_rdata_o}, exp0[mon_rd0]);
                        mon_rd0++;
                    end else begin
                        chk("m0_unexpected_r", m0_rvalid_o, 0);
                    end
                    last_done = 1'b0;
                end
                if (m1_rvalid_o && m1_rready_i) begin
                    if (mon_rd1 < exp1.size()) begin
                        chk("m1_rresp_rdata", {m1_rresp_o, m1_rdata_o}, exp1[mon_rd1]);
                        mon_rd1++;
                    end else begin
                        chk("m1_unexpected_r", m1_rvalid_o, 0);
                    end
                    last_done = 1'b1;
                end

                ar_hs = s_arvalid_o & s_arready_i;
                r_hs  = in_r & s_rvalid_i & s_rready_o;
                if (ar_hs) in_r = 1'b1;
                else if (r_hs) in_r = 1'b0;
                prev_req  = {m1_arvalid_i, m0_arvalid_i};
                prev_pend = {m1_arvalid_i & ~m1_arready_o, m0_arvalid_i & ~m0_arready_o};
                prev_sarv = s_arvalid_o;
            end
        end
    end

    initial begin
        int          base, n, n0, n1, g0, g1, cyc;
        logic [31:0] a;
        rst = 1'b0;
        m0_araddr_i = '0; m1_araddr_i = '0; m0_arvalid_i = 1'b0; m1_arvalid_i = 1'b0;
        m0_rready_i = 1'b0; m1_rready_i = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid_ready", {s_arvalid_o, s_rready_o, m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o}, 0);
            chk("idle_araddr", s_araddr_o, 0);
        end

        // Single m0 read
        ar_lat_min = 2; ar_lat_max = 2; r_lat_min = 1; r_lat_max = 1;
        request(0, 32'h8000_0000);
        #3;
        chk("m0_ar_not_before_edge", s_arvalid_o, 0);
        @(posedge clk);
        #2;
        chk("m0_ar_one_cycle_later", {s_arvalid_o, s_araddr_o}, {1'b1, 32'h8000_0000});
        drain("single_m0");

        // Simultaneous requests
        ar_lat_min = 0; ar_lat_max = 1; r_lat_min = 0; r_lat_max = 2;
        base = glog.size();
        request(0, 32'h0000_0100);
        request(1, 32'h0000_0200);
        drain("simul");
        chk("simul_grant_count", glog.size() - base, 2);
        if (glog.size() >= base + 2) begin
            chk("simul_first", glog[base], 1);
            chk("simul_second", glog[base + 1], 0);
        end

        // Continuous contention from a fresh reset
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        base = glog.size();
        n = 0;
        while (glog.size() < base + 4 && n < 400) begin
            if (!m0_arvalid_i) begin a = $urandom; a[31] = 1'b0; request(0, a); end
            if (!m1_arvalid_i) begin a = $urandom; a[31] = 1'b1; request(1, a); end
            step();
            n++;
        end
        drain("contend");
        chk("contend_grant_count", 64'(glog.size() >= base + 4), 1);
        if (glog.size() >= base + 4) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk("contend_order", {glog[base], glog[base + 1], glog[base + 2], glog[base + 3]}, 4'b0101);
`else
            chk("contend_order", {glog[base], glog[base + 1], glog[base + 2], glog[base + 3]}, 4'b1111);
`endif
        end

        // R backpressure from granted m1 with m0 waiting
        base = glog.size();
        rr_mode1 = 2; m1_rready_i = 1'b0;
        request(1, 32'h8000_1230);
        n = 0;
        while (!m1_rvalid_o && n < 50) begin step(); n++; end
        chk("bp_m1_rvalid_seen", m1_rvalid_o, 1);
        request(0, 32'h0000_4560);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {s_rready_o, m1_rvalid_o, m0_arready_o, s_arvalid_o}, 4'b0100);
        end
        rr_mode1 = 0;
        drain("bp");
        chk("bp_grant_count", glog.size() - base, 2);
        if (glog.size() >= base + 2) chk("bp_order", {glog[base], glog[base + 1]}, 2'b10);

        // Asynchronous reset during R
        rr_mode0 = 2; m0_rready_i = 1'b0;
        request(0, 32'h0000_0770);
        n = 0;
        while (!m0_rvalid_o && n < 50) begin step(); n++; end
        chk("rst_mid_r_rvalid_seen", m0_rvalid_o, 1);
        #5 rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_r");
        m0_arvalid_i = 1'b0; m0_araddr_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        rr_mode0 = 0;
        step();
        request(0, 32'h0000_0040);
        drain("after_rst");

        // Randomised traffic
        rr_mode0 = 1; rr_mode1 = 1;
        ar_lat_min = 0; ar_lat_max = 3; r_lat_min = 0; r_lat_max = 3;
        n0 = 0; n1 = 0; g0 = 0; g1 = 0; cyc = 0;
        while ((n0 < 60 || n1 < 60) && cyc < 4000) begin
            step();
            cyc++;
            if (!m0_arvalid_i && n0 < 60) begin
                if (g0 == 0) begin
                    a = $urandom; a[31] = 1'b0; request(0, a); n0++;
                    g0 = int'($urandom_range(4, 0));
                end else g0--;
            end
            if (!m1_arvalid_i && n1 < 60) begin
                if (g1 == 0) begin
                    a = $urandom; a[31] = 1'b1; request(1, a); n1++;
                    g1 = int'($urandom_range(4, 0));
                end else g1--;
            end
        end
        chk("rand_issued", n0 + n1, 120);
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the AXI-lite read channel (AR + R).
- Lets the instruction fetch unit (master 0) and the load/store unit (master 1) share the single instruction/data SRAM.
- Sits between the fetch and load/store FSMs and the SRAM.
- Supports one outstanding transaction at a time; the grant is held until the R handshake completes.

Parameters:
- ADDR_W, 32, address width (matches the instruction address bus).
- DATA_W, 32, read data width.
- RESP_W, 2, rresp width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- m0_araddr_i  in  ADDR_W  master 0 (fetch) read address.
- m0_arvalid_i  in  1  master 0 AR valid.
- m0_arready_o  out  1  master 0 AR ready.
- m0_rdata_o  out  DATA_W  master 0 read data.
- m0_rresp_o  out  RESP_W  master 0 read response.
- m0_rvalid_o  out  1  master 0 R valid.
- m0_rready_i  in  1  master 0 R ready.
- m1_araddr_i, m1_arvalid_i, m1_arready_o, m1_rdata_o, m1_rresp_o, m1_rvalid_o, m1_rready_i: same widths and directions, for master 1 (load/store).
- s_araddr_o  out  ADDR_W  slave read address.
- s_arvalid_o  out  1  slave AR valid.
- s_arready_i  in  1  slave AR ready.
- s_rdata_i  in  DATA_W  slave read data.
- s_rresp_i  in  RESP_W  slave read response.
- s_rvalid_i  in  1  slave R valid.
- s_rready_o  out  1  slave R ready.

Behaviour:
- State register: IDLE, AR, R, plus a 1-bit grant register gnt (0 = m0, 1 = m1).
- Reset (rst low, asynchronous):
  - state = IDLE, gnt = 0.
  - All valid and ready outputs are 0.
  - Data, address and rresp outputs are 0.
- Reset mid-transaction aborts it immediately. No handshake completes in that cycle. Masters restart from scratch.
- IDLE:
  - If either arvalid is 1, the picker chooses a winner. gnt is loaded and state becomes AR at the next edge.
  - If neither is 1, stay in IDLE.
  - All arready and rvalid outputs are 0.
- AR:
  - s_arvalid_o = 1.
  - s_araddr_o = araddr of the granted master.
  - Granted master's arready = s_arready_i; the other master's arready = 0.
  - On s_arvalid_o & s_arready_i, go to R.
- R:
  - Granted master's rvalid = s_rvalid_i; its rdata and rresp = s_rdata_i and s_rresp_i.
  - s_rready_o = granted master's rready.
  - Non-granted master sees rvalid = 0, rdata = 0, rresp = 0.
  - On s_rvalid_i & s_rready_o, go to IDLE.
- Latency:
  - First AR at the slave appears 1 cycle after arvalid is seen in IDLE.
  - Back-to-back transactions have one IDLE bubble between R done and the next AR.
- Masters must hold arvalid and araddr stable until arready (AXI rule). The arbiter does not latch the address.
- A request that arrives while another is in flight waits. Its arvalid stays high; it is granted at the next IDLE.
- Fixed priority (macro undefined): master 1 wins on simultaneous requests.
- arvalid dropping while in AR is a protocol violation. Behaviour is unspecified, and the bench asserts it never occurs.
- All outputs are combinational functions of (state, gnt, inputs). No output depends on the arvalid inputs in IDLE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Add a 1-bit last register, reset to 1.
  - On simultaneous requests, grant the master != last.
  - last updates to gnt when the R handshake completes.
  - A single requester is always granted.
- Undefined: fixed priority, master 1 wins. No last register exists.

Decomposition:
- Shared package/defines:
  - State encoding constants ARB_IDLE = 2'd0, ARB_AR = 2'd1, ARB_R = 2'd2.
  - Grant ids GNT_M0 = 1'b0, GNT_M1 = 1'b1.
  - Default widths: ADDR 32, DATA 32, RESP 2.
- One natural sub-module: rd_arb_pick. It is combinational: inputs req[1:0] and last; outputs winner and any. It holds the fixed and round-robin logic under the macro.
- The FSM and routing muxes stay in axi_rd_arbiter.

Test Plan:
- Reset then idle: hold rst low 3 cycles, then release with no requests -> all valid/ready outputs stay 0 for 10 cycles; s_araddr_o = 0.
- Single m0 read: m0 arvalid, addr 0x80000000; slave returns arready after 2 cycles, then rdata 0xDEADBEEF, rresp 0 -> s_araddr_o = 0x80000000 one cycle after the request; m0 gets rvalid with 0xDEADBEEF; m1_rvalid_o stays 0.
- Simultaneous requests, macro undefined: m0 addr 0x100, m1 addr 0x200 in the same cycle -> slave sees 0x200 first, then 0x100. Each completes with exactly one rvalid pulse to its own master.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined: both masters request continuously for 4 transactions -> grant order m0, m1, m0, m1.
- R backpressure: granted m1 holds rready = 0 for 5 cycles while s_rvalid_i = 1 -> state stays R, s_rready_o = 0, and a pending m0 request is not granted until m1 accepts.
- Async reset mid-R: assert rst low between clock edges during R -> all outputs go 0 immediately; after release, a new m0 request completes normally.
